// File: rtl/gals_consumer_pkg.sv
// gals_consumer_pkg: shared FSM encodings, defaults and dwell helper for the GALS consumer
package gals_consumer_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int DWELL_UNIT_DEF = 4;
    localparam int CNT_W_DEF      = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    // minimum number of cycles a word stays presented for a given dwell select
    function automatic int dwell_cycles(input int unit, input logic [2:0] prog);
        return unit * (int'(prog) + 1);
    endfunction

endpackage

// File: rtl/gals_consumer_dwell_counter.sv
// gals_consumer_dwell_counter: loadable down-counter that saturates at zero and flags it
module gals_consumer_dwell_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // load takes priority; decrement stops once zero is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gals_consumer.sv
// gals_consumer: pops words from the GALS buffer, presents each for a minimum dwell, releases on ready
module gals_consumer
    import gals_consumer_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DWELL_UNIT = DWELL_UNIT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic [2:0]        i_prog,
    input  logic              i_buffer_empty,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_rd_en,
    output logic [DATA_W-1:0] o_data_2,
    output logic              o_data_2_valid,
    input  logic              i_data_2_ready,
    output logic              o_parity,
    output logic [CNT_W-1:0]  o_word_count,
    output logic              o_drained
);

    localparam int DCW = $clog2(DWELL_UNIT * 8);

    state_t             r_state;
    state_t             w_next;
    logic               w_start;
    logic               w_release;
    logic               w_zero;
    logic [DCW-1:0]     w_load_val;
    logic [DATA_W-1:0]  r_data;
    logic               r_parity;
    logic               r_valid;
    logic [CNT_W-1:0]   r_count;

    assign w_load_val = DCW'(dwell_cycles(DWELL_UNIT, i_prog) - 1);

    // pop only from idle with data available and never while reset is held; release after dwell and ready
    always_comb begin
        w_start   = rst_n && r_state == S_IDLE && i_enable && !i_buffer_empty;
        w_release = r_state == S_HOLD && w_zero && i_data_2_ready;
        w_next    = r_state == S_IDLE ? (w_start ? S_READ : S_IDLE) :
                    r_state == S_READ ? S_LOAD :
                    r_state == S_LOAD ? S_HOLD :
                    (w_release ? S_IDLE : S_HOLD);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // capture the word in S_LOAD, clear valid and count on release; data and parity persist afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_parity <= 1'b0;
            r_valid  <= 1'b0;
            r_count  <= '0;
        end else if (r_state == S_LOAD) begin
            r_data   <= i_rd_data;
            r_parity <= ^i_rd_data;
            r_valid  <= 1'b1;
        end else if (w_release) begin
            r_valid  <= 1'b0;
            r_count  <= r_count + 1'b1;
        end
    end

    gals_consumer_dwell_counter #(
        .W(DCW)
    ) u_dwell (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (r_state == S_LOAD),
        .i_load_val(w_load_val),
        .i_dec     (r_state == S_HOLD),
        .o_zero    (w_zero)
    );

    assign o_rd_en        = w_start;
    assign o_data_2       = r_data;
    assign o_data_2_valid = r_valid;
    assign o_parity       = r_parity;
    assign o_word_count   = r_count;
    assign o_drained      = r_state == S_IDLE && i_buffer_empty && !r_valid;

endmodule

// File: tb/tb_gals_consumer.sv
// tb_gals_consumer: randomized and directed checks of gals_consumer against a timeline model
module tb_gals_consumer;

    localparam int DW = 16;
    localparam int DU = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic buffer_empty = 1'b1;
    logic ready = 1'b0;
    logic [2:0] prog = 3'd0;
    logic [DW-1:0] rd_data = '0;
    logic rd_en, valid, parity, drained;
    logic [DW-1:0] data_2;
    logic [CW-1:0] wc;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] fifo[$];

    always #5 clk = ~clk;

    gals_consumer #(.DATA_W(DW), .DWELL_UNIT(DU), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_prog(prog),
        .i_buffer_empty(buffer_empty), .i_rd_data(rd_data), .o_rd_en(rd_en),
        .o_data_2(data_2), .o_data_2_valid(valid), .i_data_2_ready(ready),
        .o_parity(parity), .o_word_count(wc), .o_drained(drained)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    // buffer read port: data appears the cycle after the pop strobe and holds
    always @(posedge clk) begin
        if (rd_en && fifo.size() > 0) begin
            rd_data <= fifo[0];
            fifo.delete(0);
        end
    end

    // timeline model: pop at cycle p, valid from p+3, release at first ready cycle >= p+2+dwell
    int k = 0, pop_k = 0, dw = DU, vcur = 0, last_vlen = 0, pops = 0, last_pop = -1;
    int gaps[$];
    logic busy = 1'b0;
    logic [DW-1:0] m_word = '0, m_data = '0;
    logic [CW-1:0] m_cnt = '0;

    always @(negedge clk) begin
        logic ev, er;
        k++;
        if (!rst_n) begin
            busy = 1'b0; m_data = '0; m_cnt = '0; vcur = 0; last_pop = -1;
            chk("rst_rd_en", rd_en, 0);
            chk("rst_valid", valid, 0);
            chk("rst_data", data_2, 0);
            chk("rst_parity", parity, 0);
            chk("rst_count", wc, 0);
            chk("rst_drained", drained, buffer_empty);
        end else begin
            if (busy && k == pop_k + 2) dw = DU * (int'(prog) + 1);
            if (busy && k == pop_k + 3) m_data = m_word;
            ev = busy && k >= pop_k + 3;
            er = !busy && enable && !buffer_empty;
            chk("rd_en", rd_en, er);
            chk("valid", valid, ev);
            chk("data_2", data_2, m_data);
            chk("parity", parity, ^m_data);
            chk("word_count", wc, m_cnt);
            chk("drained", drained, !busy && buffer_empty);
            if (rd_en) begin
                if (last_pop >= 0) gaps.push_back(k - last_pop);
                last_pop = k;
                pops++;
            end
            if (valid) vcur++;
            else if (vcur > 0) begin last_vlen = vcur; vcur = 0; end
            if (busy && k >= pop_k + 2 + dw && ready) begin busy = 1'b0; m_cnt++; end
            if (er) begin busy = 1'b1; pop_k = k; m_word = fifo[0]; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        buffer_empty = (fifo.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo.push_back(w);
        buffer_empty = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid && n < 100) begin tick(); n++; end
        chk("wait_valid", valid, 1);
    endtask

    initial begin
        int p0, g0;
        push(16'h0007); enable = 1'b1; prog = 3'd0; ready = 1'b1;
        repeat (5) tick();
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rd_en_first_idle", rd_en, 1);
        repeat (10) tick();
        chk("single_data", data_2, 16'h0007);
        chk("single_parity", parity, 1);
        chk("single_vlen", last_vlen, 4);
        chk("single_count", wc, 1);

        ready = 1'b0; prog = 3'd1;
        push(16'h00A5);
        wait_valid();
        p0 = pops;
        push(16'h1234);
        repeat (19) tick();
        chk("bp_still_valid", valid, 1);
        ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_no_pop", pops, p0);
        tick(); tick();
        chk("bp_vlen", last_vlen, 20);
        chk("bp_count", wc, 2);
        repeat (15) tick();
        chk("bp_next_vlen", last_vlen, 8);
        chk("bp_next_data", data_2, 16'h1234);
        chk("bp_next_count", wc, 3);

        prog = 3'd0;
        g0 = gaps.size();
        push(16'h0001); push(16'h0002); push(16'h0003);
        repeat (30) tick();
        chk("stream_pops", gaps.size() - g0, 3);
        chk("stream_gap1", gaps[g0 + 1], 7);
        chk("stream_gap2", gaps[g0 + 2], 7);
        chk("stream_data", data_2, 16'h0003);
        chk("stream_count", wc, 6);
        chk("stream_drained", drained, 1);

        push(16'h00F0); push(16'h000F);
        wait_valid();
        enable = 1'b0; prog = 3'd7;
        p0 = pops;
        repeat (25) tick();
        chk("mid_vlen", last_vlen, 4);
        chk("mid_no_pop", pops, p0);
        chk("mid_data", data_2, 16'h00F0);
        chk("mid_count", wc, 7);
        chk("mid_not_drained", drained, 0);
        prog = 3'd0; enable = 1'b1;
        repeat (12) tick();
        chk("mid_resume_count", wc, 8);

        p0 = pops;
        repeat (50) tick();
        chk("empty_no_pop", pops, p0);
        chk("empty_drained", drained, 1);

        for (int i = 0; i < 8; i++) push(DW'(16'h0100 + i));
        repeat (8 * 7 + 5) tick();
        chk("wrap_count", wc, 0);
        chk("wrap_data", data_2, 16'h0107);

        for (int i = 0; i < 900; i++) begin
            tick();
            ready = $urandom_range(0, 3) != 0;
            enable = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 9) == 0) prog = 3'($urandom_range(0, 7));
            if (fifo.size() < 3 && $urandom_range(0, 2) == 0) push(DW'($urandom));
            if (i == 450) rst_n = 1'b0;
            if (i == 452) rst_n = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
